mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  Bus initiator for the 16x8 memory_module: drives address/read/write/data_in, samples data_out.
//  Takes one CPU request at a time over a valid/ready handshake.
//  Performs direct or indirect access (M[M[a]]) and returns a one-cycle response.
//  Sits between the CPU control unit and memory_module.
// PARAMETERS
//  ADDR_W       4  memory address width
//  DATA_W       8  memory data width (must be >= ADDR_W)
//  WAIT_CYCLES  1  cycles each memory access phase is held; legal range 1..15, 0 is illegal
// PORTS
//  clk           in   1       rising-edge clock
//  rst_n         in   1       asynchronous active-low reset
//  req_valid     in   1       CPU request present
//  req_ready     out  1       controller idle; request accepted when req_valid & req_ready at a clk edge
//  req_write     in   1       1 = write, 0 = read
//  req_indirect  in   1       1 = req_addr points to a pointer word
//  req_addr      in   ADDR_W  request address
//  req_wdata     in   DATA_W  write data
//  rsp_valid     out  1       one-cycle completion pulse
//  rsp_rdata     out  DATA_W  read data (write: echo of captured wdata); valid when rsp_valid=1
//  mem_address   out  ADDR_W  to memory address
//  mem_read      out  1       to memory read
//  mem_write     out  1       to memory write
//  mem_data_in   out  DATA_W  to memory data_in
//  mem_data_out  in   DATA_W  from memory data_out
// BEHAVIOUR
//  Reset (rst_n low, async): state IDLE, wait counter 0, captured regs 0; req_ready=1, rsp_valid=0,
//   rsp_rdata=0, mem_read=0, mem_write=0, mem_address=0, mem_data_in=0. No request accepted while rst_n low.
//  All outputs decode from registered state only (no combinational path from req_* to mem_*).
//  FSM states: IDLE, PTR, ACCESS, RESP.
//   IDLE: req_ready=1. On accept: capture addr, wdata, write, indirect; clear counter;
//     go to PTR if indirect, else ACCESS.
//   PTR: mem_read=1, mem_address=captured addr. Counter counts 0..WAIT_CYCLES-1.
//     In the last cycle: eff_addr <= mem_data_out[ADDR_W-1:0] (upper bits ignored); clear counter; go to ACCESS.
//   ACCESS: mem_address=eff_addr (direct: eff_addr=captured addr).
//     Read: mem_read=1; latch mem_data_out into rsp_rdata in the last count cycle.
//     Write: mem_write=1, mem_data_in=captured wdata; rsp_rdata <= wdata.
//     After WAIT_CYCLES cycles go to RESP.
//   RESP: rsp_valid=1 for exactly 1 cycle, mem_read=mem_write=0, req_ready=0; go to IDLE.
//  Latency (accept edge to rsp_valid high): direct = WAIT_CYCLES+1 cycles; indirect = 2*WAIT_CYCLES+1.
//  Throughput: next accept no earlier than the cycle after RESP. No response backpressure.
//  mem_read and mem_write are never high together; both are low in IDLE and RESP.
//  req_valid in non-IDLE states is ignored (req_ready=0). The CPU holds the request until accepted.
//  Indirect write: pointer read, then write to M[ptr]. The pointer word itself is never modified.
//  rsp_rdata holds its value until the next completion.
//  rst_n asserted mid-operation: mem_write/mem_read drop immediately (async).
//   The in-flight request is dropped with no rsp_valid; req_ready=1 after release.
// TESTING (standard image: M[9]=0x08, M[10]=0x02, M[12]=0x09)
//  1 WAIT=1, direct read addr 0xA -> mem_read=1 with mem_address=0xA for 1 cycle;
//    rsp_valid 2 cycles after accept; rsp_rdata=0x02.
//  2 WAIT=1, indirect read addr 0xC -> PTR reads 0x09, ACCESS at 0x9; rsp_rdata=0x08 at 3 cycles.
//    Set M[12]=0xF3 -> eff_addr=0x3.
//  3 Direct write 0x5/0x3C, then direct read 0x5 -> rsp_rdata=0x3C.
//    Assert mem_read&mem_write never 1 throughout.
//  4 Indirect write addr 0xC, wdata 0x55 -> M[9]=0x55, M[12] stays 0x09; rsp_rdata=0x55.
//  5 WAIT=3: req_valid held high continuously for a direct request followed by an indirect one ->
//    one accept each; latencies 4 and 7; req_ready low between accepts.
//  6 rst_n pulsed low during an ACCESS write -> mem_write=0 within the reset cycle, no rsp_valid;
//    req_ready=1 after release; the next read completes normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Bus initiator for a 16x8 memory: one CPU request at a time, direct or indirect (M[M[a]]) access,
// with every memory access phase held for WAIT_CYCLES clocks and a one-cycle completion pulse.
module mem_access_ctrl #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_indirect,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PTR    = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  state_t            state_r, state_s;
  logic [3:0]        cnt_r, cnt_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [ADDR_W-1:0] eff_addr_r, eff_addr_s;
  logic [DATA_W-1:0] wdata_r, wdata_s;
  logic              write_r, write_s;
  logic [DATA_W-1:0] rdata_r, rdata_s;
  logic              last_s;

  assign last_s = (cnt_r == CNT_LAST);

  // State and captured-request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      addr_r     <= {ADDR_W{1'b0}};
      eff_addr_r <= {ADDR_W{1'b0}};
      wdata_r    <= {DATA_W{1'b0}};
      write_r    <= 1'b0;
      rdata_r    <= {DATA_W{1'b0}};
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      addr_r     <= addr_s;
      eff_addr_r <= eff_addr_s;
      wdata_r    <= wdata_s;
      write_r    <= write_s;
      rdata_r    <= rdata_s;
    end
  end

  // Next-state logic; each memory phase runs its counter from 0 to WAIT_CYCLES-1
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    addr_s     = addr_r;
    eff_addr_s = eff_addr_r;
    wdata_s    = wdata_r;
    write_s    = write_r;
    rdata_s    = rdata_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          addr_s     = req_addr;
          eff_addr_s = req_addr;
          wdata_s    = req_wdata;
          write_s    = req_write;
          cnt_s      = 4'd0;
          state_s    = req_indirect ? PTR : ACCESS;
        end else begin
          state_s = IDLE;
        end
      end
      PTR: begin
        if (last_s) begin
          eff_addr_s = mem_data_out[ADDR_W-1:0];
          cnt_s      = 4'd0;
          state_s    = ACCESS;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      ACCESS: begin
        if (last_s) begin
          rdata_s = write_r ? wdata_r : mem_data_out;
          cnt_s   = 4'd0;
          state_s = RESP;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Bus and handshake outputs decoded from registered state only
  always_comb begin
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = {ADDR_W{1'b0}};
    mem_data_in = {DATA_W{1'b0}};
    case (state_r)
      IDLE: begin
        req_ready = 1'b1;
      end
      PTR: begin
        mem_read    = 1'b1;
        mem_address = addr_r;
      end
      ACCESS: begin
        mem_address = eff_addr_r;
        if (write_r) begin
          mem_write   = 1'b1;
          mem_data_in = wdata_r;
        end else begin
          mem_read = 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

  assign rsp_rdata = rdata_r;

endmodule
